// File: rtl/warp_register_file.sv
// warp_register_file: per-thread register file with two registered full-warp read ports,
// one lane-masked write port, a pending-load scoreboard and same-cycle write forwarding.
// Ports:
//   i_clk, i_reset          clock; asynchronous active-high reset
//   i_wr_*                  writeback strobe, warp, register, lane mask, lane data
//   o_wr_err                registered pulse when a write targets a read-only special
//   i_sb_set_*              mark (warp, reg) as awaiting load data
//   o_warp_pending          per-warp OR of the pending bits
//   i_instr_rd_*/o_instr_*  issue read port (stall, valid, data) plus o_thread_idx
//   i_push_rd_*/o_push_*    FIFO-push read port (stall, valid, data)
//   i_block_idx/i_block_dim launch constants served by the top two special registers
module warp_register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_WARPS  = 4,
    parameter int WARP_SIZE  = 8,
    parameter int NUM_REGS   = 16,
    localparam int WARP_W    = $clog2(NUM_WARPS),
    localparam int REG_W     = $clog2(NUM_REGS),
    localparam int LANES_W   = DATA_WIDTH * WARP_SIZE
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_wr_en,
    input  logic [WARP_W-1:0]  i_wr_warp,
    input  logic [REG_W-1:0]   i_wr_addr,
    input  logic [WARP_SIZE-1:0] i_wr_mask,
    input  logic [LANES_W-1:0] i_wr_data,
    output logic               o_wr_err,
    input  logic               i_sb_set_en,
    input  logic [WARP_W-1:0]  i_sb_set_warp,
    input  logic [REG_W-1:0]   i_sb_set_addr,
    output logic [NUM_WARPS-1:0] o_warp_pending,
    input  logic               i_instr_rd_en,
    input  logic [WARP_W-1:0]  i_instr_rd_warp,
    input  logic [REG_W-1:0]   i_instr_rd_addr,
    output logic               o_instr_rd_stall,
    output logic               o_instr_rd_valid,
    output logic [LANES_W-1:0] o_instr_rd_data,
    output logic [LANES_W-1:0] o_thread_idx,
    input  logic               i_push_rd_en,
    input  logic [WARP_W-1:0]  i_push_rd_warp,
    input  logic [REG_W-1:0]   i_push_rd_addr,
    output logic               o_push_rd_stall,
    output logic               o_push_rd_valid,
    output logic [LANES_W-1:0] o_push_rd_data,
    input  logic [7:0]         i_block_idx,
    input  logic [7:0]         i_block_dim
);
    localparam int NUM_GEN = NUM_REGS - 3;
    localparam logic [REG_W-1:0] GEN_LIM = REG_W'(NUM_GEN);
    localparam logic [REG_W-1:0] R_TID   = REG_W'(NUM_REGS - 3);
    localparam logic [REG_W-1:0] R_BIDX  = REG_W'(NUM_REGS - 2);
    logic [LANES_W-1:0] r_mem [NUM_WARPS][NUM_GEN];
    logic [NUM_GEN-1:0] r_sb [NUM_WARPS];
    logic               r_wr_err, r_instr_valid, r_push_valid;
    logic [LANES_W-1:0] r_instr_data, r_thread_idx, r_push_data;
    logic               w_instr_stall, w_push_stall;
    logic [LANES_W-1:0] w_instr_data, w_push_data, w_tid;
    function automatic logic f_hit(input logic [WARP_W-1:0] warp, input logic [REG_W-1:0] addr);
        return i_wr_en && i_wr_warp == warp && i_wr_addr == addr;
    endfunction
    // Specials have no storage; clamp their index so array lookups stay in range.
    function automatic logic [REG_W-1:0] f_idx(input logic [REG_W-1:0] addr);
        return addr < GEN_LIM ? addr : '0;
    endfunction
    function automatic logic f_stall(input logic en, input logic [WARP_W-1:0] warp,
                                     input logic [REG_W-1:0] addr);
        return en && addr < GEN_LIM && r_sb[warp][f_idx(addr)] && !f_hit(warp, addr);
    endfunction
    function automatic logic [LANES_W-1:0] f_tid(input logic [WARP_W-1:0] warp);
        logic [LANES_W-1:0] t;
        t = '0;
        for (int l = 0; l < WARP_SIZE; l++)
            t[l*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(int'(warp) * WARP_SIZE + l);
        return t;
    endfunction
    // Stored value, special value, or same-cycle writeback data per lane.
    function automatic logic [LANES_W-1:0] f_read(input logic [WARP_W-1:0] warp,
                                                  input logic [REG_W-1:0] addr);
        logic [LANES_W-1:0] v, t;
        v = r_mem[warp][f_idx(addr)];
        t = f_tid(warp);
        for (int l = 0; l < WARP_SIZE; l++)
            v[l*DATA_WIDTH +: DATA_WIDTH] =
                addr == R_TID  ? t[l*DATA_WIDTH +: DATA_WIDTH] :
                addr == R_BIDX ? DATA_WIDTH'(i_block_idx) :
                addr >= GEN_LIM ? DATA_WIDTH'(i_block_dim) :
                (f_hit(warp, addr) && i_wr_mask[l]) ? i_wr_data[l*DATA_WIDTH +: DATA_WIDTH] :
                v[l*DATA_WIDTH +: DATA_WIDTH];
        return v;
    endfunction
    assign w_instr_stall = f_stall(i_instr_rd_en, i_instr_rd_warp, i_instr_rd_addr);
    assign w_push_stall  = f_stall(i_push_rd_en, i_push_rd_warp, i_push_rd_addr);
    assign w_instr_data  = f_read(i_instr_rd_warp, i_instr_rd_addr);
    assign w_push_data   = f_read(i_push_rd_warp, i_push_rd_addr);
    assign w_tid         = f_tid(i_instr_rd_warp);
    always_comb begin
        o_warp_pending = '0;
        for (int w = 0; w < NUM_WARPS; w++)
            o_warp_pending[w] = |r_sb[w];
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_sb[w] <= '0;
                for (int a = 0; a < NUM_GEN; a++)
                    r_mem[w][a] <= '0;
            end
            r_wr_err      <= 1'b0;
            r_instr_valid <= 1'b0;
            r_push_valid  <= 1'b0;
            r_instr_data  <= '0;
            r_thread_idx  <= '0;
            r_push_data   <= '0;
        end else begin
            r_wr_err <= i_wr_en && i_wr_addr >= GEN_LIM;
            for (int w = 0; w < NUM_WARPS; w++) begin
                for (int a = 0; a < NUM_GEN; a++) begin
                    for (int l = 0; l < WARP_SIZE; l++)
                        if (f_hit(WARP_W'(w), REG_W'(a)) && i_wr_mask[l])
                            r_mem[w][a][l*DATA_WIDTH +: DATA_WIDTH] <= i_wr_data[l*DATA_WIDTH +: DATA_WIDTH];
                    // A fresh load issue outranks the writeback clearing the same bit.
                    if (i_sb_set_en && i_sb_set_warp == WARP_W'(w) && i_sb_set_addr == REG_W'(a))
                        r_sb[w][a] <= 1'b1;
                    else if (f_hit(WARP_W'(w), REG_W'(a)))
                        r_sb[w][a] <= 1'b0;
                end
            end
            r_instr_valid <= i_instr_rd_en && !w_instr_stall;
            r_push_valid  <= i_push_rd_en && !w_push_stall;
            if (i_instr_rd_en && !w_instr_stall) begin
                r_instr_data <= w_instr_data;
                r_thread_idx <= w_tid;
            end
            if (i_push_rd_en && !w_push_stall)
                r_push_data <= w_push_data;
        end
    end
    assign o_wr_err         = r_wr_err;
    assign o_instr_rd_stall = w_instr_stall;
    assign o_instr_rd_valid = r_instr_valid;
    assign o_instr_rd_data  = r_instr_data;
    assign o_thread_idx     = r_thread_idx;
    assign o_push_rd_stall  = w_push_stall;
    assign o_push_rd_valid  = r_push_valid;
    assign o_push_rd_data   = r_push_data;
endmodule

// File: tb/tb_warp_register_file.sv
// tb_warp_register_file: directed and random checks of warp_register_file against a reference model.
module tb_warp_register_file;
    localparam int DW = 16, NW = 4, WS = 8, NR = 16, NG = 13, LW = DW * WS;
    logic          clk = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_wr_en, i_sb_set_en, i_instr_rd_en, i_push_rd_en;
    logic [1:0]    i_wr_warp, i_sb_set_warp, i_instr_rd_warp, i_push_rd_warp;
    logic [3:0]    i_wr_addr, i_sb_set_addr, i_instr_rd_addr, i_push_rd_addr;
    logic [WS-1:0] i_wr_mask;
    logic [LW-1:0] i_wr_data;
    logic [7:0]    i_block_idx, i_block_dim;
    logic          o_wr_err, o_instr_rd_stall, o_instr_rd_valid, o_push_rd_stall, o_push_rd_valid;
    logic [NW-1:0] o_warp_pending;
    logic [LW-1:0] o_instr_rd_data, o_thread_idx, o_push_rd_data;
    always #5 clk = ~clk;
    warp_register_file #(.DATA_WIDTH(DW), .NUM_WARPS(NW), .WARP_SIZE(WS), .NUM_REGS(NR)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_wr_en(i_wr_en), .i_wr_warp(i_wr_warp), .i_wr_addr(i_wr_addr),
        .i_wr_mask(i_wr_mask), .i_wr_data(i_wr_data), .o_wr_err(o_wr_err),
        .i_sb_set_en(i_sb_set_en), .i_sb_set_warp(i_sb_set_warp), .i_sb_set_addr(i_sb_set_addr),
        .o_warp_pending(o_warp_pending),
        .i_instr_rd_en(i_instr_rd_en), .i_instr_rd_warp(i_instr_rd_warp),
        .i_instr_rd_addr(i_instr_rd_addr), .o_instr_rd_stall(o_instr_rd_stall),
        .o_instr_rd_valid(o_instr_rd_valid), .o_instr_rd_data(o_instr_rd_data),
        .o_thread_idx(o_thread_idx),
        .i_push_rd_en(i_push_rd_en), .i_push_rd_warp(i_push_rd_warp),
        .i_push_rd_addr(i_push_rd_addr), .o_push_rd_stall(o_push_rd_stall),
        .o_push_rd_valid(o_push_rd_valid), .o_push_rd_data(o_push_rd_data),
        .i_block_idx(i_block_idx), .i_block_dim(i_block_dim)
    );
    typedef struct {
        logic          v;
        logic [LW-1:0] d;
        logic [LW-1:0] t;
        logic          pv;
        logic [LW-1:0] pd;
        logic          e;
    } exp_t;
    exp_t          q[$];
    logic [DW-1:0] m_mem [NW][NG][WS];
    logic          m_sb [NW][NG];
    logic [LW-1:0] m_idata, m_tid, m_pdata;
    int            n_checks = 0, n_err = 0;
    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic m_hit(input int w, input int a);
        return i_wr_en && int'(i_wr_warp) == w && int'(i_wr_addr) == a;
    endfunction
    function automatic logic m_stall(input logic en, input int w, input int a);
        return en && (a < NG ? m_sb[w][a] : 1'b0) && !m_hit(w, a);
    endfunction
    function automatic logic [LW-1:0] m_tidf(input int w);
        logic [LW-1:0] r;
        for (int l = 0; l < WS; l++) r[l*DW +: DW] = DW'(w * WS + l);
        return r;
    endfunction
    function automatic logic [LW-1:0] m_read(input int w, input int a);
        logic [LW-1:0] r;
        for (int l = 0; l < WS; l++)
            r[l*DW +: DW] = a == 13 ? DW'(w * WS + l) :
                            a == 14 ? DW'(i_block_idx) :
                            a == 15 ? DW'(i_block_dim) :
                            (m_hit(w, a) && i_wr_mask[l]) ? i_wr_data[l*DW +: DW] : m_mem[w][a][l];
        return r;
    endfunction
    function automatic logic [NW-1:0] m_pend();
        logic [NW-1:0] p;
        p = '0;
        for (int w = 0; w < NW; w++)
            for (int a = 0; a < NG; a++) p[w] = p[w] | m_sb[w][a];
        return p;
    endfunction
    function automatic logic [LW-1:0] ramp(input logic [DW-1:0] b, input int s);
        logic [LW-1:0] r;
        for (int l = 0; l < WS; l++) r[l*DW +: DW] = b + DW'(l * s);
        return r;
    endfunction
    task automatic model_clear();
        for (int w = 0; w < NW; w++)
            for (int a = 0; a < NG; a++) begin
                m_sb[w][a] = 1'b0;
                for (int l = 0; l < WS; l++) m_mem[w][a][l] = '0;
            end
        m_idata = '0;
        m_tid   = '0;
        m_pdata = '0;
        q.delete();
    endtask
    task automatic idle();
        i_wr_en = 0; i_sb_set_en = 0; i_instr_rd_en = 0; i_push_rd_en = 0;
        i_wr_warp = 0; i_sb_set_warp = 0; i_instr_rd_warp = 0; i_push_rd_warp = 0;
        i_wr_addr = 0; i_sb_set_addr = 0; i_instr_rd_addr = 0; i_push_rd_addr = 0;
        i_wr_mask = 0; i_wr_data = 0;
    endtask
    task automatic wr(input int w, input int a, input logic [WS-1:0] m, input logic [LW-1:0] d);
        i_wr_en = 1; i_wr_warp = 2'(w); i_wr_addr = 4'(a); i_wr_mask = m; i_wr_data = d;
    endtask
    task automatic rd_i(input int w, input int a);
        i_instr_rd_en = 1; i_instr_rd_warp = 2'(w); i_instr_rd_addr = 4'(a);
    endtask
    task automatic rd_p(input int w, input int a);
        i_push_rd_en = 1; i_push_rd_warp = 2'(w); i_push_rd_addr = 4'(a);
    endtask
    task automatic sb(input int w, input int a);
        i_sb_set_en = 1; i_sb_set_warp = 2'(w); i_sb_set_addr = 4'(a);
    endtask
    // Entered just after a falling edge with inputs driven; leaves at the next falling edge.
    task automatic cycle();
        exp_t e;
        logic si, sp;
        int   ww, wa;
        #1;
        si = m_stall(i_instr_rd_en, int'(i_instr_rd_warp), int'(i_instr_rd_addr));
        sp = m_stall(i_push_rd_en, int'(i_push_rd_warp), int'(i_push_rd_addr));
        chk("instr_stall", LW'(o_instr_rd_stall), LW'(si));
        chk("push_stall", LW'(o_push_rd_stall), LW'(sp));
        chk("warp_pending", LW'(o_warp_pending), LW'(m_pend()));
        if (i_instr_rd_en && !si) begin
            m_idata = m_read(int'(i_instr_rd_warp), int'(i_instr_rd_addr));
            m_tid   = m_tidf(int'(i_instr_rd_warp));
        end
        if (i_push_rd_en && !sp) m_pdata = m_read(int'(i_push_rd_warp), int'(i_push_rd_addr));
        e.v  = i_instr_rd_en && !si;
        e.d  = m_idata;
        e.t  = m_tid;
        e.pv = i_push_rd_en && !sp;
        e.pd = m_pdata;
        e.e  = i_wr_en && int'(i_wr_addr) >= NG;
        q.push_back(e);
        ww = int'(i_wr_warp);
        wa = int'(i_wr_addr);
        if (i_wr_en && wa < NG) begin
            for (int l = 0; l < WS; l++)
                if (i_wr_mask[l]) m_mem[ww][wa][l] = i_wr_data[l*DW +: DW];
            m_sb[ww][wa] = 1'b0;
        end
        if (i_sb_set_en && int'(i_sb_set_addr) < NG) m_sb[int'(i_sb_set_warp)][int'(i_sb_set_addr)] = 1'b1;
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("instr_valid", LW'(o_instr_rd_valid), LW'(e.v));
        chk("instr_data", o_instr_rd_data, e.d);
        chk("thread_idx", o_thread_idx, e.t);
        chk("push_valid", LW'(o_push_rd_valid), LW'(e.pv));
        chk("push_data", o_push_rd_data, e.pd);
        chk("wr_err", LW'(o_wr_err), LW'(e.e));
        @(negedge clk);
    endtask
    task automatic do_reset();
        i_reset = 1;
        #1;
        chk("rst_instr_valid", LW'(o_instr_rd_valid), '0);
        chk("rst_instr_data", o_instr_rd_data, '0);
        chk("rst_thread_idx", o_thread_idx, '0);
        chk("rst_push_valid", LW'(o_push_rd_valid), '0);
        chk("rst_push_data", o_push_rd_data, '0);
        chk("rst_wr_err", LW'(o_wr_err), '0);
        chk("rst_pending", LW'(o_warp_pending), '0);
        chk("rst_stalls", LW'({o_instr_rd_stall, o_push_rd_stall}), '0);
        model_clear();
        @(posedge clk);
        #1;
        chk("rst_held_valid", LW'(o_push_rd_valid), '0);
        @(negedge clk);
        i_reset = 0;
    endtask
    initial begin
        idle();
        i_block_idx = 8'd3;
        i_block_dim = 8'd32;
        #2;
        do_reset();
        wr(2, 5, 8'hFF, ramp(16'h0100, 1));
        cycle();
        idle(); rd_i(2, 5);
        cycle();
        chk("t1_lane3", LW'(o_instr_rd_data[3*DW +: DW]), LW'(16'h0103));
        chk("t1_tid7", LW'(o_thread_idx[7*DW +: DW]), LW'(16'd23));
        idle(); wr(1, 3, 8'hFF, ramp(16'h1111, 0));
        cycle();
        idle(); wr(1, 3, 8'h0F, ramp(16'hAAAA, 0)); rd_i(1, 3); rd_p(1, 3);
        cycle();
        chk("t2_fwd_lane0", LW'(o_instr_rd_data[0 +: DW]), LW'(16'hAAAA));
        chk("t2_fwd_lane4", LW'(o_push_rd_data[4*DW +: DW]), LW'(16'h1111));
        idle(); rd_p(1, 3);
        cycle();
        chk("t2_store_lane3", LW'(o_push_rd_data[3*DW +: DW]), LW'(16'hAAAA));
        idle(); sb(0, 7);
        cycle();
        idle(); rd_i(0, 7);
        repeat (3) cycle();
        chk("t3_pending", LW'(o_warp_pending), LW'(4'b0001));
        chk("t3_stall", LW'(o_instr_rd_stall), LW'(1'b1));
        wr(0, 7, 8'hFF, ramp(16'h0700, 1));
        cycle();
        chk("t3_fwd_lane6", LW'(o_instr_rd_data[6*DW +: DW]), LW'(16'h0706));
        idle();
        cycle();
        chk("t3_pending_clr", LW'(o_warp_pending), '0);
        idle(); wr(3, 13, 8'hFF, ramp(16'hDEAD, 0)); sb(3, 13);
        cycle();
        chk("t4_wr_err", LW'(o_wr_err), LW'(1'b1));
        idle(); rd_i(3, 13); rd_p(3, 14);
        cycle();
        chk("t4_tid_lane5", LW'(o_instr_rd_data[5*DW +: DW]), LW'(16'd29));
        chk("t4_bidx", LW'(o_push_rd_data[0 +: DW]), LW'(16'd3));
        idle(); rd_i(3, 15);
        cycle();
        chk("t4_bdim", LW'(o_instr_rd_data[2*DW +: DW]), LW'(16'd32));
        idle(); sb(2, 1); wr(2, 1, 8'hFF, ramp(16'h2100, 1));
        cycle();
        idle(); rd_i(2, 1);
        cycle();
        chk("t6_stall", LW'(o_instr_rd_stall), LW'(1'b1));
        rd_p(2, 5);
        cycle();
        chk("t5_push_valid", LW'(o_push_rd_valid), LW'(1'b1));
        do_reset();
        idle(); rd_p(2, 5);
        cycle();
        chk("t5_after_rst", o_push_rd_data, '0);
        for (int k = 0; k < 80; k++) begin
            i_wr_en       = 1'($urandom_range(0, 1));
            i_wr_warp     = 2'($urandom_range(0, 3));
            i_wr_addr     = 4'($urandom_range(10, 15));
            i_wr_mask     = 8'($urandom);
            i_wr_data     = {$urandom, $urandom, $urandom, $urandom};
            i_sb_set_en   = 1'($urandom_range(0, 1));
            i_sb_set_warp = 2'($urandom_range(0, 3));
            i_sb_set_addr = 4'($urandom_range(10, 15));
            rd_i($urandom_range(0, 3), $urandom_range(10, 15));
            rd_p($urandom_range(0, 3), $urandom_range(10, 15));
            i_instr_rd_en = 1'($urandom_range(0, 1));
            i_push_rd_en  = 1'($urandom_range(0, 1));
            cycle();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/warp_register_file.md
# warp_register_file

Parametrised per-thread register file for the compute unit. It holds NUM_REGS registers for each of NUM_WARPS × WARP_SIZE threads and serves one full-warp read per port per cycle. It has two registered read ports (instruction issue and FIFO push) and one lane-masked write port (LSU/ALU writeback). A per-register pending-load scoreboard stalls reads of registers whose load data has not yet returned, and same-cycle writeback data is forwarded to the read ports.

## Interface
- DATA_WIDTH, 16, bits per register
- NUM_WARPS, 4, warps resident in the compute unit (power of 2, ≥2)
- WARP_SIZE, 8, threads (lanes) per warp
- NUM_REGS, 16, registers per thread (power of 2, ≥8); top three are read-only specials
- Derived: WARP_W = $clog2(NUM_WARPS), REG_W = $clog2(NUM_REGS), LANES_W = DATA_WIDTH*WARP_SIZE; lane i of any lane bus is [i*DATA_WIDTH +: DATA_WIDTH]

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- wr_en  in  1  writeback strobe
- wr_warp  in  WARP_W  writeback warp
- wr_addr  in  REG_W  writeback register
- wr_mask  in  WARP_SIZE  per-lane write enable
- wr_data  in  LANES_W  writeback data
- wr_err  out  1  registered pulse: write targeted a read-only register
- sb_set_en  in  1  load issued: mark (sb_set_warp, sb_set_addr) pending
- sb_set_warp  in  WARP_W  scoreboard warp
- sb_set_addr  in  REG_W  scoreboard register
- warp_pending  out  NUM_WARPS  bit w = any register of warp w pending (combinational from scoreboard flops)
- instr_rd_en  in  1  issue-port read request
- instr_rd_warp  in  WARP_W / instr_rd_addr  in  REG_W  issue-port target
- instr_rd_stall  out  1  combinational: request rejected this cycle
- instr_rd_valid  out  1  registered: instr data valid
- instr_rd_data  out  LANES_W  registered read data
- thread_idx  out  LANES_W  registered global thread index per lane, to AGU
- push_rd_en / push_rd_warp / push_rd_addr  in  1 / WARP_W / REG_W  push-port request
- push_rd_stall  out  1 / push_rd_valid  out  1 / push_rd_data  out  LANES_W  as issue port
- blockIdx  in  8  block index, stable during a launch
- blockDim  in  8  threads per block, stable during a launch

## Operation
- Storage: NUM_WARPS×WARP_SIZE×(NUM_REGS−3) general registers in flops. Specials are not stored:
  - reg NUM_REGS−3 reads warp*WARP_SIZE+lane
  - reg NUM_REGS−2 reads zero-extended blockIdx
  - reg NUM_REGS−1 reads zero-extended blockDim
- Write: when wr_en=1 and wr_addr < NUM_REGS−3, each lane with wr_mask[i]=1 is updated. When wr_addr ≥ NUM_REGS−3, storage is unchanged and wr_err=1 next cycle.
- Scoreboard: one pending bit per (warp, general reg).
  - sb_set_en sets the bit.
  - A wr_en to the same (warp, reg) clears it, regardless of wr_mask.
  - Simultaneous set and clear of the same bit: set wins (a new load has been issued).
  - sb_set_en on a special register is ignored.
- Read request on a port is stalled iff rd_en=1 and the target's pending bit is 1 and no wr_en hits the same (warp, reg) this cycle. Specials never stall.
- Non-stalled request: next cycle rd_valid=1 and rd_data = stored value. Lanes written this cycle (same warp, reg, mask bit 1) return wr_data instead (forwarding).
- No request or stalled request: rd_valid=0 next cycle; rd_data holds its previous value.
- thread_idx updates alongside instr_rd_data on every non-stalled instr request; it is independent of instr_rd_addr.
- Both ports may read the same or different (warp, reg) in the same cycle; there are no port conflicts.

## Timing
- Read latency: 1 cycle from accepted request to rd_valid/data. Throughput: 1 request per port per cycle.
- Write visible in storage the following cycle; visible to a read in the same cycle only via forwarding.
- Stall outputs are combinational from the scoreboard flops and same-cycle wr_* inputs. The requester re-presents the request on a later cycle; no request is queued.
- Reset (asynchronous, any time, including mid-read):
  - all general registers 0 and all pending bits 0
  - warp_pending=0, rd_valid=0, rd_data=0, thread_idx=0, wr_err=0
  - stall outputs 0 while reset is held
  - an in-flight read is dropped
- thread_idx arithmetic: warp*WARP_SIZE+lane is computed in DATA_WIDTH bits and truncates on overflow.

## Test plan
- Reset, write warp 2 reg 5 mask 8'hFF lanes = 16'h0100+i, then read instr port warp 2 reg 5 next cycle -> valid=1 one cycle later, lane i = 16'h0100+i, thread_idx lane i = 16+i.
- Write warp 1 reg 3 mask 8'h0F data 16'hAAAA while simultaneously reading warp 1 reg 3 (previously 16'h1111) -> lanes 0–3 = AAAA, lanes 4–7 = 1111 (forwarding); storage matches the next cycle.
- sb_set warp 0 reg 7; read reg 7 for 3 cycles -> stall=1, valid=0, warp_pending=4'b0001. Then writeback reg 7 with a concurrent read -> stall=0, forwarded data, warp_pending=0.
- Write reg 13 (blockIdx=3, blockDim=32) -> wr_err pulse. Reads of regs 13/14/15 on warp 3 -> lane i = 24+i, 3, 32; no stall.
- Assert reset one cycle after an accepted push read -> push_rd_valid=0, data 0. Re-read after release returns 0.
- Simultaneous sb_set and writeback on warp 2 reg 1 -> bit remains set; the next read stalls.
